bounce_decoder: RTL
===================

// Module: bounce_decoder
// PURPOSE
//  Receive-side monitor for the supercar light bar: samples the N_BIT one-hot pattern driven by the
//  bouncing shift register and decodes lit position, travel direction and end-of-bar bounces.
//  Flags any illegal pattern or step. Feeds the status display and self-check logic downstream of the bar.
// PARAMETERS
//  N_BIT   4  width of the light bar; legal range 2..32
//  CNT_W   8  width of the bounce counter
//  POS_W   $clog2(N_BIT)  localparam; width of pos
// PORTS
//  clk         in   1        system clock, rising edge
//  rst_n       in   1        asynchronous reset, active low
//  en          in   1        sample strobe; same enable that advances the shifter, 1-cycle pulse
//  pin         in   N_BIT    light pattern from the shifter's pout
//  clr_err     in   1        clears err and forces resync
//  pos         out  POS_W    binary index of lit bit, bit0 = 0
//  dir         out  1        1 = moving toward MSB, 0 = toward LSB
//  valid       out  1        pos/dir trustworthy (TRACK state)
//  bounce      out  1        1-cycle pulse on a legal reversal at an end
//  bounce_cnt  out  CNT_W    count of legal bounces, wraps modulo 2^CNT_W
//  err         out  1        sticky error flag
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=EMPTY, pos=0, dir=0, valid=0, bounce=0, bounce_cnt=0, err=0, prev=0.
//  - All state updates only on clk edges with en=1, except bounce (cleared every cycle without en) and clr_err.
//  - Each en sample classifies pin: ZERO (all 0), ONE (exactly one bit), MULTI (>1 bit).
//  - Outputs register on the en edge; 1-cycle latency from sample to pos/dir/valid/bounce.
//  - States: EMPTY, ACQUIRE, TRACK, ERROR.
//   EMPTY:   ZERO -> stay; ONE -> ACQUIRE, prev=pin, pos=index; MULTI -> ERROR.
//   ACQUIRE: ONE and pin==prev<<1 -> TRACK, dir=1; pin==prev>>1 -> TRACK, dir=0;
//            pin==prev -> stay; ZERO -> EMPTY; any other -> ERROR.
//            Special: prev at MSB and pin==prev>>1 -> TRACK dir=0; prev at LSB and pin==prev<<1 -> TRACK dir=1
//            (no bounce pulse from ACQUIRE).
//   TRACK:   valid=1. pin==prev -> hold (shifter stalled). Step in dir -> pos updates.
//            Step against dir allowed only when prev is the end bit in dir (MSB when dir=1, LSB when dir=0):
//            dir toggles, bounce=1, bounce_cnt+1. Reversal elsewhere, non-adjacent step, MULTI -> ERROR.
//            ZERO -> EMPTY (bar drained), valid=0, bounce_cnt kept.
//   ERROR:   err=1, valid=0, pos/dir frozen. Leaves only via clr_err.
//  - clr_err=1 (any cycle, en ignored): err=0, state=EMPTY, prev=0; bounce_cnt kept. clr_err has priority
//    over an en sample in the same cycle.
//  - Shifts are logical within N_BIT; MSB<<1 and LSB>>1 evaluate to zero and never match ONE.
//  - bounce_cnt wraps 2^CNT_W-1 -> 0 with no flag.
//  - N_BIT=2: both bits are ends; every step is a bounce after the first.
//  - Reset mid-operation: immediate return to reset values; first post-reset sample re-acquires.
// STRUCTURE
//  - Shared include ../lib/bounce_defs.vh: state encodings (S_EMPTY, S_ACQUIRE, S_TRACK, S_ERROR, 2 bits)
//    and pattern-class codes (C_ZERO, C_ONE, C_MULTI).
//  - One sub-module: onehot_enc #(N_BIT) -- combinational pattern classifier + one-hot-to-binary index
//    (outputs class, index); reused by other bar monitors.
//  - Top: registered FSM, prev register, direction/bounce logic, counter.
// TESTING
//  - N_BIT=4, reset, en pulses with pin=0000 -> state EMPTY, valid=0, all outputs 0.
//  - pin 0001,0010,0100,1000,0100,0010,0001,0010 on en -> valid from 2nd sample, dir 1 then 0 then 1,
//    bounce pulses after samples 5 and 8, bounce_cnt=2, pos tracks 0..3..0..1.
//  - In TRACK dir=1 at 0010, sample 0001 -> err=1, valid=0; clr_err -> err=0, EMPTY; 0100,1000 -> re-lock dir=1.
//  - Sample 0110 in any state -> ERROR; jump 0001->0100 -> ERROR.
//  - Same pin held over 5 en pulses, en=0 with pin changing -> no state change, no bounce.
//  - CNT_W=2, run 5 bounces -> bounce_cnt 1,2,3,0,1; assert rst_n low mid-sweep -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bounce_decoder_pkg.sv
// Shared types for the light-bar monitors: FSM states and
// pattern classes produced by the one-hot classifier.
package bounce_decoder_pkg;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        C_ZERO  = 2'd0,
        C_ONE   = 2'd1,
        C_MULTI = 2'd2
    } pclass_t;

endpackage

// File: rtl/bounce_decoder_onehot_enc.sv
// Combinational pattern classifier: ZERO / ONE / MULTI plus the
// binary index of the lit bit (meaningful only for ONE).
module onehot_enc
    import bounce_decoder_pkg::*;
#(
    parameter  int N_BIT = 4,
    localparam int POS_W = $clog2(N_BIT)
) (
    input  logic [N_BIT-1:0] pin,
    output pclass_t          cls,
    output logic [POS_W-1:0] idx
);

    logic seen;
    logic multi;

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_BIT; i++) begin
            if (pin[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
                idx  = POS_W'(i);
            end
        end
    end

    always_comb begin
        cls = C_ZERO;
        if (multi)     cls = C_MULTI;
        else if (seen) cls = C_ONE;
    end

endmodule

// File: rtl/bounce_decoder.sv
// Receive-side monitor for the bouncing light bar: tracks the lit
// position and direction, counts end bounces, flags illegal steps.
module bounce_decoder
    import bounce_decoder_pkg::*;
#(
    parameter  int N_BIT = 4,
    parameter  int CNT_W = 8,
    localparam int POS_W = $clog2(N_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_BIT-1:0] pin,
    input  logic             clr_err,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             valid,
    output logic             bounce,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic             err
);

    state_t           state_q, state_d;
    logic [N_BIT-1:0] prev_q, prev_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             bounce_q, bounce_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    pclass_t          cls;
    logic [POS_W-1:0] idx;

    onehot_enc #(.N_BIT(N_BIT)) u_enc (
        .pin (pin),
        .cls (cls),
        .idx (idx)
    );

    logic [N_BIT-1:0] shl, shr;
    logic is_one, is_zero;
    logic hold, up, down;
    logic fwd, back, at_end;

    // Logical shifts: stepping off either end yields zero, never ONE.
    assign shl     = prev_q << 1;
    assign shr     = prev_q >> 1;
    assign is_one  = (cls == C_ONE);
    assign is_zero = (cls == C_ZERO);
    assign hold    = is_one && (pin == prev_q);
    assign up      = is_one && (pin == shl);
    assign down    = is_one && (pin == shr);
    assign fwd     = dir_q ? up : down;
    assign back    = dir_q ? down : up;
    assign at_end  = dir_q ? prev_q[N_BIT-1] : prev_q[0];

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_d = 1'b0;
        cnt_d    = cnt_q;
        if (clr_err) begin
            state_d = S_EMPTY;
            prev_d  = '0;
        end else if (en) begin
            unique case (state_q)
                S_EMPTY: begin
                    unique case (cls)
                        C_ZERO: ;
                        C_ONE: begin
                            state_d = S_ACQUIRE;
                            prev_d  = pin;
                            pos_d   = idx;
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
                S_ACQUIRE: begin
                    unique case (1'b1)
                        is_zero: state_d = S_EMPTY;
                        hold: ;
                        up: begin
                            state_d = S_TRACK;
                            dir_d   = 1'b1;
                            prev_d  = pin;
                            pos_d   = idx;
                        end
                        down: begin
                            state_d = S_TRACK;
                            dir_d   = 1'b0;
                            prev_d  = pin;
                            pos_d   = idx;
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
                S_TRACK: begin
                    unique case (1'b1)
                        is_zero: state_d = S_EMPTY;
                        hold: ;
                        fwd: begin
                            prev_d = pin;
                            pos_d  = idx;
                        end
                        (back && at_end): begin
                            prev_d   = pin;
                            pos_d    = idx;
                            dir_d    = ~dir_q;
                            bounce_d = 1'b1;
                            cnt_d    = cnt_q + CNT_W'(1);
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
                S_ERROR: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            prev_q   <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            bounce_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pos        = pos_q;
    assign dir        = dir_q;
    assign valid      = (state_q == S_TRACK);
    assign bounce     = bounce_q;
    assign bounce_cnt = cnt_q;
    assign err        = (state_q == S_ERROR);

endmodule
